rr_merge: RTL and testbench

Round-robin merge of N show-ahead FIFO sources into one show-ahead output stream, with a bounded burst length per source. It sits between several producer FIFOs or prefetch stages and a single consumer, and each word is tagged with the index of the source it came from. It provides one registered output slot and sustains one word per cycle.

---
 rtl/rr_merge.sv | 75 +++++++
 tb/tb_rr_merge.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_merge.sv
// Round-robin merge of N show-ahead sources into one registered show-ahead slot, id-tagged, up to B grants per burst.
// Latency one clock from source to out; full slot with get_o=0 holds out/id and raises no get_i.
module rr_merge #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int B  = 1,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N*W-1:0] in,
  output logic [N-1:0]   get_i,
  input  logic [N-1:0]   empty_i,
  output logic [W-1:0]   out,
  output logic [IW-1:0]  id,
  input  logic           get_o,
  output logic           empty_o
);

  localparam int RW = $clog2(B + 1);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [RW-1:0] BMAX = RW'(B);

  logic [IW-1:0] cur;
  logic [IW-1:0] g;
  logic [RW-1:0] run;
  logic [RW-1:0] run_nxt;
  logic          load;
  logic          found;

  // Stay on cur while its burst has room, otherwise scan from cur+1 with cur itself last.
  always_comb begin
    g     = cur;
    found = 1'b0;
    if ((run < BMAX) && !empty_i[cur]) begin
      found = 1'b1;
    end
    for (int off = 1; off <= N; off++) begin
      int idx;
      idx = (int'(cur) + off) % N;
      if (!found && !empty_i[idx]) begin
        g     = IW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    load    = (empty_o | get_o) & (|(~empty_i)) & ~reset;
    get_i   = load ? (N'(1) << g) : '0;
    run_nxt = RW'(1);
    if (g == cur) begin
      run_nxt = (run < BMAX) ? run + 1'b1 : BMAX;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out     <= '0;
      id      <= '0;
      empty_o <= 1'b1;
      cur     <= LAST;
      run     <= BMAX;
    end else if (load) begin
      out     <= in[int'(g)*W +: W];
      id      <= g;
      empty_o <= 1'b0;
      run     <= run_nxt;
      cur     <= g;
    end else if (get_o) begin
      empty_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_merge.sv
// Bench for rr_merge: instance a (B=1) and instance b (B=2), each fed by queue-modelled sources.
module tb_rr_merge;
  localparam int W = 8;
  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [N*W-1:0] in_a, in_b;
  logic [N-1:0] gi_a, gi_b, ei_a, ei_b;
  logic [W-1:0] out_a, out_b;
  logic [1:0]   id_a, id_b;
  logic         go_a, go_b, eo_a, eo_b;

  logic [7:0] mem [2][N][256];
  int         hd [2][N];
  int         tl [2][N];
  logic       hold [2][N];
  logic [1:0] flush_req;

  logic       mfull;
  logic [7:0] mdat;
  logic [1:0] mid;
  int         wt [N];
  int         maxw;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  rr_merge #(.W(W), .N(N), .B(1)) dut_a (
    .clock(clock), .reset(reset), .in(in_a), .get_i(gi_a), .empty_i(ei_a),
    .out(out_a), .id(id_a), .get_o(go_a), .empty_o(eo_a));

  rr_merge #(.W(W), .N(N), .B(2)) dut_b (
    .clock(clock), .reset(reset), .in(in_b), .get_i(gi_b), .empty_i(ei_b),
    .out(out_b), .id(id_b), .get_o(go_b), .empty_o(eo_b));

  always_comb begin
    in_a = '0;
    in_b = '0;
    ei_a = '0;
    ei_b = '0;
    for (int k = 0; k < N; k++) begin
      ei_a[k] = (hd[0][k] == tl[0][k]) || hold[0][k];
      ei_b[k] = (hd[1][k] == tl[1][k]) || hold[1][k];
      in_a[k*W +: W] = mem[0][k][hd[0][k] % 256];
      in_b[k*W +: W] = mem[1][k][hd[1][k] % 256];
    end
  end

  function automatic logic [7:0] wd(input int k, input int j);
    return 8'((k << 6) | (j & 63));
  endfunction

  // Source pops are decided from get_i just before the edge and applied just after it.
  initial begin : source_model
    logic [N-1:0] sa, sb, eb;
    logic gb;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < N; k++) hd[d][k] = 0;
    for (int k = 0; k < N; k++) wt[k] = 0;
    mfull = 1'b0; mdat = '0; mid = '0; maxw = 0;
    forever begin
      @(negedge clock);
      #4;
      sa = gi_a; sb = gi_b; eb = ei_b;
      gb = go_b & ~eo_b;
      @(posedge clock);
      #1;
      if (reset) begin
        mfull = 1'b0;
      end else if (|sb) begin
        mfull = 1'b1;
        for (int k = 0; k < N; k++)
          if (sb[k]) begin
            mdat = mem[1][k][hd[1][k] % 256];
            mid  = 2'(k);
          end
      end else if (gb) begin
        mfull = 1'b0;
      end
      for (int k = 0; k < N; k++) begin
        if (reset || eb[k] || sb[k]) wt[k] = 0;
        else if (|sb) begin
          wt[k]++;
          if (wt[k] > maxw) maxw = wt[k];
        end
      end
      for (int k = 0; k < N; k++) begin
        if (flush_req[0]) hd[0][k] = tl[0][k];
        else if (sa[k]) hd[0][k]++;
        if (flush_req[1]) hd[1][k] = tl[1][k];
        else if (sb[k]) hd[1][k]++;
      end
    end
  end

  task automatic push(input int d, input int k, input int j);
    mem[d][k][tl[d][k] % 256] = wd(k, j);
    tl[d][k]++;
  endtask

  // Drain both instances, then reset so each scenario starts with cur=N-1.
  task automatic prep();
    go_a = 1'b1; go_b = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < N; k++) hold[d][k] = 1'b0;
    flush_req = 2'b11;
    repeat (3) @(negedge clock);
    flush_req = 2'b00;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    go_a = 1'b0; go_b = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (eo_a !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b want=1", eo_a); end
    total++; if (out_a !== 8'h00 || id_a !== 2'd0) begin bad++; $display("FAIL rst_out got=%h/%0d want=00/0", out_a, id_a); end
    total++; if (gi_a !== 4'b0000 || gi_b !== 4'b0000) begin bad++; $display("FAIL rst_get got=%b/%b want=0000", gi_a, gi_b); end
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    total++; if (eo_a !== 1'b1 || eo_b !== 1'b1) begin bad++; $display("FAIL rst_idle got=%b%b want=11", eo_a, eo_b); end
    push(0, 1, 5);
    @(negedge clock);
    total++; if (eo_a !== 1'b0 || out_a !== wd(1, 5) || id_a !== 2'd1) begin
      bad++; $display("FAIL rst_load got=%b/%h/%0d want=0/%h/1", eo_a, out_a, id_a, wd(1, 5)); end
    push(0, 3, 7);
    go_a = 1'b1;
    #2 reset = 1'b1;
    #1;
    total++; if (eo_a !== 1'b1 || gi_a !== 4'b0000 || out_a !== 8'h00) begin
      bad++; $display("FAIL rst_async got=%b/%b/%h want=1/0000/00", eo_a, gi_a, out_a); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++; if (eo_a !== 1'b0 || out_a !== wd(3, 7) || id_a !== 2'd3) begin
      bad++; $display("FAIL rst_after got=%b/%h/%0d want=0/%h/3", eo_a, out_a, id_a, wd(3, 7)); end
  endtask

  task automatic test_single();
    prep();
    for (int j = 0; j < 3; j++) push(0, 2, 16 + j);
    go_a = 1'b1;
    #1;
    total++; if (gi_a !== 4'b0100) begin bad++; $display("FAIL single_get0 got=%b want=0100", gi_a); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++; if (eo_a !== 1'b0 || out_a !== wd(2, 16 + i) || id_a !== 2'd2) begin
        bad++; $display("FAIL single_word%0d got=%b/%h/%0d want=0/%h/2", i, eo_a, out_a, id_a, wd(2, 16 + i)); end
      total++; if (gi_a !== ((i < 2) ? 4'b0100 : 4'b0000)) begin
        bad++; $display("FAIL single_get%0d got=%b want=%b", i + 1, gi_a, (i < 2) ? 4'b0100 : 4'b0000); end
    end
    @(negedge clock);
    total++; if (eo_a !== 1'b1) begin bad++; $display("FAIL single_drain got=%b want=1", eo_a); end
  endtask

  task automatic test_round_robin();
    prep();
    for (int k = 0; k < N; k++)
      for (int j = 0; j < 12; j++) push(0, k, j);
    go_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      total++; if (id_a !== 2'(i % 4) || out_a !== wd(i % 4, i / 4) || eo_a !== 1'b0) begin
        bad++; $display("FAIL rr_%0d got=%0d/%h want=%0d/%h", i, id_a, out_a, i % 4, wd(i % 4, i / 4)); end
    end
  endtask

  task automatic test_burst();
    int exp1 [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int exp2 [7]  = '{0, 0, 1, 2, 2, 3, 3};
    int cnt [N];
    prep();
    for (int k = 0; k < N; k++) begin
      cnt[k] = 0;
      for (int j = 0; j < 4; j++) push(1, k, j);
    end
    go_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      total++; if (id_b !== 2'(exp1[i]) || out_b !== wd(exp1[i], cnt[exp1[i]])) begin
        bad++; $display("FAIL burst_%0d got=%0d/%h want=%0d/%h", i, id_b, out_b, exp1[i], wd(exp1[i], cnt[exp1[i]])); end
      cnt[exp1[i]]++;
    end
    prep();
    for (int k = 0; k < N; k++) begin
      cnt[k] = 0;
      for (int j = 0; j < ((k == 1) ? 1 : 4); j++) push(1, k, j);
    end
    go_b = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      total++; if (id_b !== 2'(exp2[i]) || out_b !== wd(exp2[i], cnt[exp2[i]])) begin
        bad++; $display("FAIL burst_short_%0d got=%0d/%h want=%0d/%h", i, id_b, out_b, exp2[i], wd(exp2[i], cnt[exp2[i]])); end
      cnt[exp2[i]]++;
    end
  endtask

  task automatic test_backpressure();
    int eid [5] = '{1, 2, 3, 0, 1};
    int eseq [5] = '{0, 0, 0, 1, 1};
    prep();
    for (int k = 0; k < N; k++)
      for (int j = 0; j < 6; j++) push(0, k, j);
    go_a = 1'b0;
    #1;
    total++; if (gi_a !== 4'b0001) begin bad++; $display("FAIL bp_first got=%b want=0001", gi_a); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      total++; if (gi_a !== 4'b0000 || eo_a !== 1'b0 || out_a !== wd(0, 0) || id_a !== 2'd0) begin
        bad++; $display("FAIL bp_hold%0d got=%b/%b/%h/%0d want=0000/0/%h/0", i, gi_a, eo_a, out_a, id_a, wd(0, 0)); end
    end
    go_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      total++; if (id_a !== 2'(eid[i]) || out_a !== wd(eid[i], eseq[i])) begin
        bad++; $display("FAIL bp_resume%0d got=%0d/%h want=%0d/%h", i, id_a, out_a, eid[i], wd(eid[i], eseq[i])); end
    end
  endtask

  task automatic test_random();
    int seq [N];
    int nxfer;
    prep();
    nxfer = 0;
    for (int k = 0; k < N; k++) seq[k] = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      if (c == 401) reset = 1'b0;
      total++; if (eo_b !== ~mfull) begin bad++; $display("FAIL rand_empty c=%0d got=%b want=%b", c, eo_b, ~mfull); end
      if (mfull) begin
        total++; if (out_b !== mdat || id_b !== mid) begin
          bad++; $display("FAIL rand_word c=%0d got=%h/%0d want=%h/%0d", c, out_b, id_b, mdat, mid); end
        if (go_b) nxfer++;
      end
      for (int k = 0; k < N; k++) begin
        if ((tl[1][k] - hd[1][k]) < 16 && $urandom_range(0, 2) == 0) begin
          push(1, k, seq[k]);
          seq[k]++;
        end
        hold[1][k] = ($urandom_range(0, 4) == 0);
      end
      go_b = ($urandom_range(0, 3) != 0);
      if (c == 400) begin
        reset = 1'b1;
        #1;
        total++; if (eo_b !== 1'b1 || gi_b !== 4'b0000) begin
          bad++; $display("FAIL rand_reset got=%b/%b want=1/0000", eo_b, gi_b); end
      end else begin
        #1;
        total++; if ($countones(gi_b) > 1) begin bad++; $display("FAIL rand_onehot c=%0d got=%b want<=1 bit", c, gi_b); end
      end
    end
    total++; if (maxw > (N - 1) * 2 || maxw == 0) begin bad++; $display("FAIL rand_fair got=%0d want=1..%0d", maxw, (N - 1) * 2); end
    total++; if (nxfer < 100) begin bad++; $display("FAIL rand_activity got=%0d want>=100", nxfer); end
  endtask

  initial begin : main
    reset = 1'b1;
    go_a = 1'b0; go_b = 1'b0;
    flush_req = 2'b00;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < N; k++) begin
        tl[d][k] = 0;
        hold[d][k] = 1'b0;
        for (int e = 0; e < 256; e++) mem[d][k][e] = '0;
      end
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_backpressure();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
